// File: rtl/pov_clock_pkg.sv
// POV clock renderer shared types and dial glyph tables.
// Glyph columns are packed col9..col0, each column 7 rows (bit 0 innermost).
package pov_clock_pkg;

  localparam int GLYPH_COLS = 10;
  localparam int GLYPH_ROWS = 7;
  localparam int GLYPH_BITS = GLYPH_COLS * GLYPH_ROWS;

  typedef enum logic [1:0] {
    HAND_NONE,
    HAND_SEC,
    HAND_MIN,
    HAND_HOUR
  } hand_e;

  typedef enum logic [1:0] {
    GLYPH_12,
    GLYPH_3,
    GLYPH_6,
    GLYPH_9
  } glyph_e;

  localparam logic [GLYPH_BITS-1:0] GLYPH_12_BITS = {
    7'b0000000, 7'b0111001, 7'b1000101, 7'b1000011, 7'b1100001,
    7'b0000000, 7'b0000001, 7'b1111111, 7'b0100001, 7'b0000000
  };

  localparam logic [GLYPH_BITS-1:0] GLYPH_3_BITS = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0110110, 7'b1001001,
    7'b1001001, 7'b1000001, 7'b0000000, 7'b0000000, 7'b0000000
  };

  localparam logic [GLYPH_BITS-1:0] GLYPH_6_BITS = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000110, 7'b1001001,
    7'b1001001, 7'b0111110, 7'b0000000, 7'b0000000, 7'b0000000
  };

  localparam logic [GLYPH_BITS-1:0] GLYPH_9_BITS = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0111110, 7'b1001001,
    7'b1001001, 7'b0110000, 7'b0000000, 7'b0000000, 7'b0000000
  };

endpackage

// File: rtl/pov_dial_rom.sv
// Dial numeral ROM: (glyph, column) -> row pattern.
// Columns past the glyph width read as dark.
module pov_dial_rom
  import pov_clock_pkg::*;
(
  input  glyph_e                glyph_sel,
  input  logic [3:0]            column,
  output logic [GLYPH_ROWS-1:0] row
);

  logic [GLYPH_BITS-1:0] bits;

  // Select the glyph table, then slice out one column
  always_comb begin
    bits = '0;
    unique case (glyph_sel)
      GLYPH_12: bits = GLYPH_12_BITS;
      GLYPH_3:  bits = GLYPH_3_BITS;
      GLYPH_6:  bits = GLYPH_6_BITS;
      GLYPH_9:  bits = GLYPH_9_BITS;
    endcase
    row = '0;
    if (column < 4'(GLYPH_COLS))
      row = bits[int'(column)*GLYPH_ROWS +: GLYPH_ROWS];
  end

endmodule

// File: rtl/pov_clock_renderer.sv
// LED-fan clock face renderer: angle tracking, time snapshot, hands and dial.
// Optional POV_MINUTE_FLASH_EN inverts the column for a revolution on minute change.
module pov_clock_renderer
  import pov_clock_pkg::*;
#(
  parameter int STEPS       = 360,
  parameter int NUM_LEDS    = 16,
  parameter int HAND_LEDS   = 8,
  parameter int HOUR_LEN    = 3,
  parameter int MIN_LEN     = 5,
  parameter int SEC_LEN     = 8,
  parameter int HAND_HALFW  = 1,
  parameter int COL_STEPS   = 3,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(STEPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fanclk,
  input  logic                index,
  input  logic [3:0]          hour,
  input  logic [5:0]          min,
  input  logic [5:0]          sec,
  input  logic                time_valid,
  output logic [NUM_LEDS-1:0] led,
  output logic [AW-1:0]       angle,
  output logic                rev_done,
  output logic                sync_err
);

  localparam int PW     = AW + 7;
  localparam int TW     = AW + 2;
  localparam int Q      = STEPS / 12;
  localparam int WIN    = GLYPH_COLS * COL_STEPS;
  localparam int HALF   = WIN / 2;
  localparam int DIAL_W = NUM_LEDS - HAND_LEDS - 1;
  localparam logic [HAND_LEDS-1:0] ONES = '1;
  localparam logic [HAND_LEDS-1:0] HOUR_M = ONES >> (HAND_LEDS - HOUR_LEN);
  localparam logic [HAND_LEDS-1:0] MIN_M  = ONES >> (HAND_LEDS - MIN_LEN);
  localparam logic [HAND_LEDS-1:0] SEC_M  = ONES >> (HAND_LEDS - SEC_LEN);

  logic [SYNC_STAGES-1:0] fan_sync_q, fan_sync_d;
  logic [SYNC_STAGES-1:0] idx_sync_q, idx_sync_d;
  logic                   fan_prev_q, fan_prev_d;
  logic                   idx_prev_q, idx_prev_d;
  logic                   step_ev, idx_ev;
  logic [AW-1:0]          angle_q, angle_d;
  logic                   rev_q, rev_d;
  logic                   err_q, err_d;
  logic [3:0]             hr_q, hr_d;
  logic [5:0]             min_q, min_d;
  logic [5:0]             sec_q, sec_d;
  logic [AW-1:0]          sec_pos_q, sec_pos_d;
  logic [AW-1:0]          min_pos_q, min_pos_d;
  logic [AW-1:0]          hour_pos_q, hour_pos_d;
  logic [NUM_LEDS-1:0]    led_q, led_d;
  hand_e                  hsel;
  logic [HAND_LEDS-1:0]   hand;
  logic [TW-1:0]          rel;
  logic                   in_win, tick;
  glyph_e                 gsel;
  logic [3:0]             gcol;
  logic [GLYPH_ROWS-1:0]  rom_row;

  function automatic logic hit(input logic [AW-1:0] a,
                               input logic [AW-1:0] p);
    logic [AW-1:0] diff;
    logic [AW-1:0] alt;
    diff = (a >= p) ? a - p : p - a;
    alt  = AW'(STEPS) - diff;
    return ((diff < alt) ? diff : alt) <= AW'(HAND_HALFW);
  endfunction

  // Synchronise strobes and detect rising edges
  always_comb begin
    fan_sync_d = {fan_sync_q[SYNC_STAGES-2:0], fanclk};
    idx_sync_d = {idx_sync_q[SYNC_STAGES-2:0], index};
    fan_prev_d = fan_sync_q[SYNC_STAGES-1];
    idx_prev_d = idx_sync_q[SYNC_STAGES-1];
    step_ev    = fan_sync_q[SYNC_STAGES-1] & ~fan_prev_q;
    idx_ev     = idx_sync_q[SYNC_STAGES-1] & ~idx_prev_q;
  end

  // Angle counter; index resync takes precedence over a step
  always_comb begin
    angle_d = angle_q;
    rev_d   = 1'b0;
    err_d   = 1'b0;
    if (idx_ev) begin
      angle_d = AW'(STEPS - 1);
      rev_d   = 1'b1;
      err_d   = (angle_q != '0);
    end else if (step_ev) begin
      if (angle_q == '0) begin
        angle_d = AW'(STEPS - 1);
        rev_d   = 1'b1;
      end else begin
        angle_d = angle_q - AW'(1);
      end
    end
  end

  // Time shadows only move at a revolution boundary
  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (rev_d && time_valid) begin
      hr_d  = (hour >= 4'd12) ? hour - 4'd12 : hour;
      min_d = min;
      sec_d = sec;
    end
  end

  // Hand angular positions derived from the shadows
  always_comb begin
    sec_pos_d  = AW'(PW'(sec_q) * PW'(STEPS) / PW'(60));
    min_pos_d  = AW'(PW'(min_q) * PW'(STEPS) / PW'(60));
    hour_pos_d = AW'((PW'(hr_q) * PW'(5) + PW'(min_q) / PW'(12))
                 * PW'(STEPS) / PW'(60));
  end

  // Hand hit test with hour > min > sec priority
  always_comb begin
    hsel = HAND_NONE;
    if (hit(angle_q, hour_pos_q))
      hsel = HAND_HOUR;
    else if (hit(angle_q, min_pos_q))
      hsel = HAND_MIN;
    else if (hit(angle_q, sec_pos_q))
      hsel = HAND_SEC;
    hand = '0;
    unique case (hsel)
      HAND_HOUR: hand = HOUR_M;
      HAND_MIN:  hand = MIN_M;
      HAND_SEC:  hand = SEC_M;
      HAND_NONE: hand = '0;
    endcase
  end

  // Locate the numeral window (12/3/6/9) and glyph column
  always_comb begin
    in_win = 1'b0;
    gsel   = GLYPH_12;
    gcol   = '0;
    rel    = '0;
    for (int k = 0; k < 4; k++) begin
      rel = TW'(angle_q) + TW'(HALF) + TW'(STEPS) - TW'(k * 3 * Q);
      if (rel >= TW'(STEPS)) rel = rel - TW'(STEPS);
      if (rel >= TW'(STEPS)) rel = rel - TW'(STEPS);
      if (rel < TW'(WIN)) begin
        in_win = 1'b1;
        gsel   = glyph_e'(2'(k));
        gcol   = 4'(rel / TW'(COL_STEPS));
      end
    end
    tick = ((angle_q % AW'(Q)) == '0) && !in_win;
  end

  pov_dial_rom u_rom (
    .glyph_sel (gsel),
    .column    (gcol),
    .row       (rom_row)
  );

`ifdef POV_MINUTE_FLASH_EN
  logic flash_q, flash_d;
  logic seen_q, seen_d;

  // Flag a minute change at a snapshot; armed only after the first one
  always_comb begin
    flash_d = flash_q;
    seen_d  = seen_q;
    if (rev_d) begin
      flash_d = time_valid && seen_q && (min != min_q);
      if (time_valid) seen_d = 1'b1;
    end
  end

  // Flash state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      flash_q <= flash_d;
      seen_q  <= seen_d;
    end
  end
`endif

  // Assemble the LED column
  always_comb begin
    led_d = '0;
    led_d[HAND_LEDS-1:0] = hand;
    if (in_win)
      led_d[NUM_LEDS-1:HAND_LEDS+1] = DIAL_W'(rom_row);
    if (tick)
      led_d[NUM_LEDS-1 -: 4] = 4'hF;
    led_d[HAND_LEDS] = in_win && (gsel == GLYPH_12);
`ifdef POV_MINUTE_FLASH_EN
    led_d = led_d ^ {NUM_LEDS{flash_q}};
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fan_sync_q <= '0;
      idx_sync_q <= '0;
      fan_prev_q <= 1'b0;
      idx_prev_q <= 1'b0;
      angle_q    <= AW'(STEPS - 1);
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_pos_q  <= '0;
      min_pos_q  <= '0;
      hour_pos_q <= '0;
      led_q      <= '0;
    end else begin
      fan_sync_q <= fan_sync_d;
      idx_sync_q <= idx_sync_d;
      fan_prev_q <= fan_prev_d;
      idx_prev_q <= idx_prev_d;
      angle_q    <= angle_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_pos_q  <= sec_pos_d;
      min_pos_q  <= min_pos_d;
      hour_pos_q <= hour_pos_d;
      led_q      <= led_d;
    end
  end

  assign led      = led_q;
  assign angle    = angle_q;
  assign rev_done = rev_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_pov_clock_renderer.sv
// Directed bench for pov_clock_renderer (default build, STEPS=360).
// Tracks the expected angle itself and checks hands, dial and pulses.
module tb_pov_clock_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fanclk;
  logic        index;
  logic [3:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        time_valid;
  logic [15:0] led;
  logic [8:0]  angle;
  logic        rev_done;
  logic        sync_err;

  int checks  = 0;
  int errors  = 0;
  int rev_cnt = 0;
  int err_cnt = 0;
  int model   = 359;

  pov_clock_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .fanclk     (fanclk),
    .index      (index),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .time_valid (time_valid),
    .led        (led),
    .angle      (angle),
    .rev_done   (rev_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rev_done) rev_cnt++;
    if (sync_err) err_cnt++;
  end

  task automatic step();
    @(posedge clk); #1 fanclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 fanclk = 1'b0;
    repeat (4) @(posedge clk);
    model = (model == 0) ? 359 : model - 1;
    @(negedge clk);
  endtask

  task automatic goto(input int t);
    for (int n = 0; n < 400 && model != t; n++) step();
  endtask

  task automatic pulse_index();
    @(posedge clk); #1 index = 1'b1;
    repeat (4) @(posedge clk);
    #1 index = 1'b0;
    repeat (4) @(posedge clk);
    model = 359;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fanclk = 1'b0; index = 1'b0;
    hour = 4'd15; min = 6'd30; sec = 6'd0; time_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (angle !== 9'd359) begin
      errors++; $display("FAIL reset_angle got %0d want 359", angle);
    end
    checks++;
    if (led !== 16'h0000) begin
      errors++; $display("FAIL reset_led got %h want 0000", led);
    end
    checks++;
    if (rev_done !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b%b want 00", rev_done, sync_err);
    end
    @(posedge clk); #1 rst = 1'b0;
    model = 359;
  endtask

  task automatic test_full_rev();
    int r0, e0;
    r0 = rev_cnt; e0 = err_cnt;
    goto(0);
    checks++;
    if (angle !== 9'd0 || rev_cnt !== r0) begin
      errors++;
      $display("FAIL rev_at0 angle %0d revs %0d want 0 0", angle, rev_cnt - r0);
    end
    step();
    checks++;
    if (angle !== 9'd359 || rev_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL rev_wrap angle %0d revs %0d want 359 1", angle, rev_cnt - r0);
    end
    checks++;
    if (err_cnt !== e0) begin
      errors++; $display("FAIL rev_syncerr got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_hands();
    int          a[9] = '{180, 102, 30, 20, 2, 1, 0, 359, 358};
    logic [15:0] m[9] = '{16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'h00FF,
                          16'h00FF, 16'h01FF, 16'h00FF, 16'h01FF};
    logic [15:0] v[9] = '{16'h001F, 16'h0007, 16'hF000, 16'h0000, 16'h0000,
                          16'h00FF, 16'h01FF, 16'h00FF, 16'h0100};
    for (int i = 0; i < 9; i++) begin
      goto(a[i]);
      checks++;
      if ((led & m[i]) !== v[i]) begin
        errors++;
        $display("FAIL hands_%0d got %h want %h", a[i], led & m[i], v[i]);
      end
    end
  endtask

  task automatic test_sec_edge();
    int         a[6] = '{356, 355, 354, 353, 352, 0};
    logic [7:0] v[6] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    sec = 6'd59;
    goto(0);
    step();
    for (int i = 0; i < 6; i++) begin
      goto(a[i]);
      checks++;
      if (led[7:0] !== v[i]) begin
        errors++;
        $display("FAIL sec59_%0d got %h want %h", a[i], led[7:0], v[i]);
      end
    end
    sec = 6'd0;
  endtask

  task automatic test_midrev();
    int         a[3] = '{180, 102, 0};
    logic [7:0] v[3] = '{8'h1F, 8'h07, 8'hFF};
    int         b[4] = '{270, 180, 108, 102};
    logic [7:0] w[4] = '{8'h1F, 8'h00, 8'h07, 8'h00};
    step();
    goto(200);
    min = 6'd45;
    for (int i = 0; i < 3; i++) begin
      goto(a[i]);
      checks++;
      if (led[7:0] !== v[i]) begin
        errors++;
        $display("FAIL midrev_%0d got %h want %h", a[i], led[7:0], v[i]);
      end
    end
    step();
    for (int i = 0; i < 4; i++) begin
      goto(b[i]);
      checks++;
      if (led[7:0] !== w[i]) begin
        errors++;
        $display("FAIL newmin_%0d got %h want %h", b[i], led[7:0], w[i]);
      end
    end
    goto(0);
    time_valid = 1'b0; min = 6'd10; hour = 4'd1;
    step();
    for (int i = 0; i < 3; i++) begin
      goto(b[2*i/2 == 0 ? 0 : (i == 1 ? 2 : 3)]);
      checks++;
      if (led[7:0] !== w[i == 0 ? 0 : (i == 1 ? 2 : 3)]) begin
        errors++;
        $display("FAIL holdtime_%0d got %h want %h", model, led[7:0],
                 w[i == 0 ? 0 : (i == 1 ? 2 : 3)]);
      end
    end
    time_valid = 1'b1; min = 6'd30; hour = 4'd15;
  endtask

  task automatic test_index();
    int r0, e0;
    goto(100);
    r0 = rev_cnt; e0 = err_cnt;
    pulse_index();
    checks++;
    if (angle !== 9'd359 || rev_cnt - r0 !== 1 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL index_100 angle %0d rev %0d err %0d want 359 1 1",
               angle, rev_cnt - r0, err_cnt - e0);
    end
    goto(0);
    r0 = rev_cnt; e0 = err_cnt;
    pulse_index();
    checks++;
    if (angle !== 9'd359 || rev_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL index_0 angle %0d rev %0d err %0d want 359 1 0",
               angle, rev_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_step_and_index();
    int r0;
    goto(200);
    r0 = rev_cnt;
    @(posedge clk); #1 fanclk = 1'b1; index = 1'b1;
    repeat (4) @(posedge clk);
    #1 fanclk = 1'b0; index = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    model = 359;
    checks++;
    if (angle !== 9'd359 || rev_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL step_index angle %0d rev %0d want 359 1",
               angle, rev_cnt - r0);
    end
  endtask

  task automatic test_reset_midrev();
    goto(50);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (angle !== 9'd359 || led !== 16'h0000) begin
      errors++;
      $display("FAIL midreset angle %0d led %h want 359 0000", angle, led);
    end
    @(posedge clk); #1 rst = 1'b0;
    model = 359;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (led[7:0] !== 8'h07) begin
      errors++;
      $display("FAIL cleared_shadow got %h want 07", led[7:0]);
    end
    goto(0);
    step();
    goto(102);
    checks++;
    if (led[7:0] !== 8'h07) begin
      errors++;
      $display("FAIL resnap_102 got %h want 07", led[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_rev();
    test_hands();
    test_sec_edge();
    test_midrev();
    test_index();
    test_step_and_index();
    test_reset_midrev();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
